// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, and a multi-cycle
// MDU wait with a watchdog, plus saturating stall/flush statistics counters.
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_branch_taken,
    input  logic             mdu_start,
    input  logic             mdu_done,
    input  logic             cnt_clr,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             EXMEM_stall,
    output logic             mdu_busy,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {IDLE, MDU_BUSY} state_t;

    localparam int WD_W = $clog2(MDU_TIMEOUT) + 1;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            load_use, wd_expire, mdu_release, timeout_hit;
    logic            pc_stall_c, ifid_stall_c, idex_bubble_c, ifid_flush_c;
    logic            exmem_stall_c, mdu_busy_c;

    assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                       (ID_use_rs2 && (ID_rs2 == EX_rd)));

    assign wd_expire   = (wd_cnt == WD_W'(MDU_TIMEOUT - 1));
    assign mdu_release = mdu_done || wd_expire;

    always_comb begin
        state_nxt     = state;
        pc_stall_c    = 1'b0;
        ifid_stall_c  = 1'b0;
        idex_bubble_c = 1'b0;
        ifid_flush_c  = 1'b0;
        exmem_stall_c = 1'b0;
        mdu_busy_c    = 1'b0;
        timeout_hit   = 1'b0;
        case (state)
            IDLE: begin
                // A taken branch squashes the wrong-path ID instruction, so its
                // load-use hazard is moot.
                if (EX_branch_taken) begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end
                if (mdu_start)
                    state_nxt = MDU_BUSY;
            end
            MDU_BUSY: begin
                // The release cycle (done or watchdog) already lets the pipe move.
                if (mdu_release) begin
                    state_nxt   = IDLE;
                    timeout_hit = wd_expire && !mdu_done;
                end else begin
                    pc_stall_c    = 1'b1;
                    ifid_stall_c  = 1'b1;
                    exmem_stall_c = 1'b1;
                    mdu_busy_c    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are held low for as long as reset is asserted, whatever the inputs.
    assign PC_stall    = rst_n && pc_stall_c;
    assign IFID_stall  = rst_n && ifid_stall_c;
    assign IDEX_bubble = rst_n && idex_bubble_c;
    assign IFID_flush  = rst_n && ifid_flush_c;
    assign EXMEM_stall = rst_n && exmem_stall_c;
    assign mdu_busy    = rst_n && mdu_busy_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            mdu_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            // Zero on entry to MDU_BUSY and whenever outside it.
            if (state == MDU_BUSY && state_nxt == MDU_BUSY)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (timeout_hit)
                mdu_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall_c && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush_c && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model pushes expected
// outputs per cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int TO    = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0;
    logic ID_use_rs1 = 0, ID_use_rs2 = 0, EX_MemRead = 0, EX_branch_taken = 0;
    logic mdu_start = 0, mdu_done = 0, cnt_clr = 0;
    logic PC_stall, IFID_stall, IDEX_bubble, IFID_flush, EXMEM_stall;
    logic mdu_busy, mdu_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .MDU_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
        .EX_branch_taken(EX_branch_taken),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .cnt_clr(cnt_clr),
        .PC_stall(PC_stall), .IFID_stall(IFID_stall),
        .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush),
        .EXMEM_stall(EXMEM_stall), .mdu_busy(mdu_busy),
        .mdu_timeout(mdu_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pc, ifid, bub, fl, exm, busy, tmo;
        int   sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc_no = 0;

    // Reference model state: are we waiting on the MDU, and for how many cycles so far.
    bit m_busy = 0, m_tmo = 0;
    int m_elapsed = 0, m_sc = 0, m_fc = 0;

    task automatic cyc(input logic rst, br, mr, input logic [4:0] exrd, r1, r2,
                       input logic u1, u2, st, dn, clr);
        exp_t e;
        bit lu, last;
        @(posedge clk);
        #2;
        rst_n = rst; EX_branch_taken = br; EX_MemRead = mr; EX_rd = exrd;
        ID_rs1 = r1; ID_rs2 = r2; ID_use_rs1 = u1; ID_use_rs2 = u2;
        mdu_start = st; mdu_done = dn; cnt_clr = clr;
        e.pc = 0; e.ifid = 0; e.bub = 0; e.fl = 0; e.exm = 0; e.busy = 0;
        if (!rst) begin
            m_busy = 0; m_tmo = 0; m_elapsed = 0; m_sc = 0; m_fc = 0;
            e.tmo = 0; e.sc = 0; e.fc = 0;
        end else begin
            e.tmo = m_tmo; e.sc = m_sc; e.fc = m_fc;
            if (m_busy) begin
                last = dn || (m_elapsed == TO - 1);
                if (!last) begin
                    e.pc = 1; e.ifid = 1; e.exm = 1; e.busy = 1;
                    m_elapsed++;
                end else begin
                    if (!dn) m_tmo = 1;
                    m_busy = 0;
                end
            end else begin
                lu = mr && exrd != 0 && ((u1 && r1 == exrd) || (u2 && r2 == exrd));
                if (br) begin
                    e.fl = 1; e.bub = 1;
                end else if (lu) begin
                    e.pc = 1; e.ifid = 1; e.bub = 1;
                end
                if (st) begin
                    m_busy = 1; m_elapsed = 0;
                end
            end
            if (clr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (e.pc && m_sc < CMAX) m_sc++;
                if (e.fl && m_fc < CMAX) m_fc++;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", cyc_no, name, act, expv);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc_no++;
                chk("PC_stall",    int'(PC_stall),    int'(e.pc));
                chk("IFID_stall",  int'(IFID_stall),  int'(e.ifid));
                chk("IDEX_bubble", int'(IDEX_bubble), int'(e.bub));
                chk("IFID_flush",  int'(IFID_flush),  int'(e.fl));
                chk("EXMEM_stall", int'(EXMEM_stall), int'(e.exm));
                chk("mdu_busy",    int'(mdu_busy),    int'(e.busy));
                chk("mdu_timeout", int'(mdu_timeout), int'(e.tmo));
                chk("stall_cnt",   int'(stall_cnt),   e.sc);
                chk("flush_cnt",   int'(flush_cnt),   e.fc);
            end
        end
    end

    initial begin : driver
        int waited;
        // Reset with hazard inputs active: outputs must stay low.
        cyc(0, 1, 1, 5, 5, 5, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Load-use on rs2, then the bubble cycle.
        cyc(1, 0, 1, 5, 0, 5, 0, 1, 0, 0, 0);
        idle(1);
        // x0 never stalls; a branch overrides load-use.
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 1, 1, 5, 0, 5, 0, 1, 0, 0, 0);
        // rs1 match but not used: no stall.
        cyc(1, 0, 1, 7, 7, 3, 0, 1, 0, 0, 0);
        idle(1);
        // MDU: start, 5 busy cycles, done; late done in IDLE ignored.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(5);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // MDU with branch/load-use ignored while busy, then watchdog timeout.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 5, 5, 5, 1, 1, 1, 0, 0);
        idle(TO + 2);
        // Reset mid-busy, then a late done.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // Saturate stall_cnt, then clear concurrent with a stall.
        for (int i = 0; i < CMAX + 3; i++) cyc(1, 0, 1, 9, 9, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 9, 9, 0, 1, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < CMAX + 2; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // Random traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 149) != 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 24) == 0));
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush statistics counters.
REQ-002 Parameter: MDU_TIMEOUT, 64, maximum MDU_BUSY cycles before the watchdog forces release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ID_rs1 / ID_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 ID_use_rs1 / ID_use_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-007 EX_MemRead  input  1  the instruction in EX is a load.
REQ-008 EX_rd  input  5  destination register of the instruction in EX.
REQ-009 EX_branch_taken  input  1  EX resolves a taken branch or jump (redirect).
REQ-010 mdu_start  input  1  EX issues a multi-cycle MUL/DIV this cycle.
REQ-011 mdu_done  input  1  MDU result valid this cycle.
REQ-012 cnt_clr  input  1  synchronous clear of the statistics counters.
REQ-013 PC_stall / IFID_stall  output  1 each  hold PC / IF-ID register.
REQ-014 IDEX_bubble  output  1  load a NOP into ID-EX.
REQ-015 IFID_flush  output  1  squash the IF-ID contents.
REQ-016 EXMEM_stall  output  1  hold EX-MEM and the ID-EX contents (EX frozen).
REQ-017 mdu_busy  output  1  FSM is in MDU_BUSY.
REQ-018 mdu_timeout  output  1  sticky watchdog flag.
REQ-019 stall_cnt / flush_cnt  output  CNT_W each  saturating statistics counters.

Function
REQ-020 FSM states: IDLE, MDU_BUSY; all outputs are combinational decodes of the state and the current inputs, except the counters and mdu_timeout, which are registered.
REQ-021 load_use = EX_MemRead & (EX_rd != 0) & ((ID_use_rs1 & ID_rs1 == EX_rd) | (ID_use_rs2 & ID_rs2 == EX_rd)).
REQ-022 IDLE, EX_branch_taken=1: IFID_flush=1, IDEX_bubble=1, PC_stall=0, IFID_stall=0; load_use is ignored (wrong path).
REQ-023 IDLE, load_use=1 and no branch: PC_stall=1, IFID_stall=1, IDEX_bubble=1 for exactly that cycle; the re-evaluation next cycle sees the bubble in EX, so there is no second stall.
REQ-024 IDLE, mdu_start=1: next state MDU_BUSY; branch/load-use outputs this cycle are per REQ-022/023.
REQ-025 MDU_BUSY: PC_stall, IFID_stall, EXMEM_stall=1; IDEX_bubble=0, IFID_flush=0; EX_branch_taken, load_use and mdu_start are ignored.
REQ-026 MDU_BUSY with mdu_done=1: all stall outputs are 0 in that same cycle; next state IDLE.
REQ-027 The watchdog counter clears on entry to MDU_BUSY and increments each MDU_BUSY cycle. When it reaches MDU_TIMEOUT-1 without mdu_done, the FSM behaves as REQ-026 that cycle and sets mdu_timeout=1, which stays set until reset.
REQ-028 mdu_done in IDLE is ignored.
REQ-029 stall_cnt increments on every cycle with PC_stall=1; flush_cnt increments on every cycle with IFID_flush=1; both saturate at all-ones and never wrap.
REQ-030 cnt_clr=1 forces both counters to 0 next edge, taking priority over an increment in the same cycle; it does not affect the FSM or mdu_timeout.
REQ-031 Register x0 never causes a load-use stall.

Reset
REQ-032 rst_n=0 immediately forces: state IDLE, watchdog 0, stall_cnt=0, flush_cnt=0, mdu_timeout=0, mdu_busy=0.
REQ-033 While in reset, all stall/flush/bubble outputs are 0 regardless of inputs.
REQ-034 Reset asserted mid-MDU_BUSY aborts the wait; after release the FSM is IDLE and ignores a late mdu_done.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_rd=5, ID_rs2=5, ID_use_rs2=1 -> one cycle of PC_stall=IFID_stall=IDEX_bubble=1, stall_cnt 0->1.
REQ-036 Same as REQ-035 with EX_rd=0, or with EX_branch_taken=1 -> no stall; in the branch case IFID_flush=IDEX_bubble=1 and flush_cnt increments by 1.
REQ-037 mdu_start pulse, then mdu_done after 5 cycles -> mdu_busy and EXMEM_stall high for 5 cycles and low in the done cycle, stall_cnt +=5, IDLE afterwards.
REQ-038 MDU_TIMEOUT=4, mdu_done never asserted -> release after 4 busy cycles, mdu_timeout=1 sticky until rst_n=0.
REQ-039 CNT_W=2, 5 stall cycles -> stall_cnt=3 (saturated); cnt_clr concurrent with a stall -> 0.
REQ-040 rst_n low for 1 cycle mid-MDU_BUSY, then mdu_done -> all outputs 0, state IDLE, counters 0.
